board_scan: RTL and testbench

Display-side reader of the Tetris playfield. It walks the locked-cell board one row at a time through the board's read port and merges in the four cells of the active piece. Each row is then serialised into a shift-register LED matrix driver (data/clock/latch). It sits between `board`/`game` and the physical display and never writes game state.

---
 rtl/board_scan_if.sv | 26 ++
 rtl/board_scan.sv | 220 ++++++++++++++++++++++
 tb/tb_board_scan.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/board_scan_if.sv
// board_scan_if: groups the board read port and the LED row-driver lines.
//   master (board_scan side): drives rd_en, rd_row, sdata, sclk, latch,
//                             row_sel; receives rd_data.
//   slave  (board / display side): the mirror image.
// Parameter COLS sets the rd_data width and must match the board_scan instance.
interface board_scan_if #(
  parameter int unsigned COLS = 10
);
  logic            rd_en;
  logic [4:0]      rd_row;
  logic [COLS-1:0] rd_data;
  logic            sdata;
  logic            sclk;
  logic            latch;
  logic [4:0]      row_sel;

  modport master (
    output rd_en, rd_row, sdata, sclk, latch, row_sel,
    input  rd_data
  );

  modport slave (
    input  rd_en, rd_row, sdata, sclk, latch, row_sel,
    output rd_data
  );
endinterface

// File: rtl/board_scan.sv
// board_scan: display-side reader of the playfield. It reads the locked-cell
// board one row per pass (top row first), optionally ORs in the active piece,
// and shifts each row MSB-first into a shift-register LED driver, then latches.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous, active-low reset
//   enable       run frames while high (a frame in progress always completes)
//   piece_x/y    four active-piece cells, snapshotted at frame start
//   piece_valid  active piece present
//   frame_done   one-cycle pulse on the first gap cycle after the last latch
//   busy         high whenever the scanner is not idle
//   bus          board read port (rd_en/rd_row/rd_data, 1-cycle latency) and
//                serial driver lines (sdata/sclk/latch/row_sel)
//
// Build option: define BOARD_SCAN_OVERLAY_EN to merge the active piece into
// the displayed rows. Without it the piece inputs are ignored and only the
// locked cells are shown; timing is identical in both builds.
module board_scan #(
  parameter int unsigned COLS      = 10,
  parameter int unsigned ROWS      = 20,
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned FRAME_GAP = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic [15:0]  piece_x,
  input  logic [19:0]  piece_y,
  input  logic         piece_valid,
  output logic         frame_done,
  output logic         busy,
  board_scan_if.master bus
);

  localparam int unsigned BIT_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned DIV_W = $clog2(CLK_DIV) + 1;
  localparam int unsigned GAP_W = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;

  localparam logic [BIT_W-1:0] BIT_TOP  = BIT_W'(COLS - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(FRAME_GAP - 1);
  localparam logic [4:0]       ROW_TOP  = 5'(ROWS - 1);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPTURE,
    SHIFT,
    LATCH,
    GAP
  } state_t;

  state_t           state, state_nxt;
  logic             frame_start;

  logic [4:0]       row_cnt, row_cnt_nxt;
  logic [BIT_W-1:0] bit_cnt, bit_nxt;
  logic [DIV_W-1:0] div_cnt, div_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_nxt;
  logic [COLS-1:0]  row_q, row_nxt;
  logic [COLS-1:0]  overlay;

  logic             rd_en_q, sdata_q, sclk_q, latch_q, busy_q, frame_done_q;
  logic [4:0]       row_sel_q;
  logic             rd_en_d, sdata_d, sclk_d, latch_d, busy_d, frame_done_d;

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = READ;
      READ:    state_nxt = CAPTURE;
      CAPTURE: state_nxt = SHIFT;
      SHIFT:   if (bit_cnt == '0 && div_cnt == DIV_LAST) state_nxt = LATCH;
      LATCH:   state_nxt = (row_cnt == '0) ? GAP : READ;
      GAP:     if (gap_cnt == GAP_LAST) state_nxt = enable ? READ : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A new frame starts only from IDLE or at the end of the gap; this is the
  // single point where the piece snapshot and the top row are loaded.
  assign frame_start = (state_nxt == READ) && (state == IDLE || state == GAP);

  // ---------------------------------------------------------------- overlay
`ifdef BOARD_SCAN_OVERLAY_EN
  logic [15:0] snap_x;
  logic [19:0] snap_y;
  logic        snap_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap_x     <= '0;
      snap_y     <= '0;
      snap_valid <= 1'b0;
    end else if (frame_start) begin
      snap_x     <= piece_x;
      snap_y     <= piece_y;
      snap_valid <= piece_valid;
    end
  end

  // Matching against every in-range column drops x>=COLS cells for free;
  // y>=ROWS can never equal the row counter, so spawn-zone cells vanish too.
  always_comb begin
    overlay = '0;
    if (snap_valid) begin
      for (int unsigned i = 0; i < 4; i++) begin
        for (int unsigned c = 0; c < COLS; c++) begin
          if (32'(snap_x[4*i +: 4]) == c && snap_y[5*i +: 5] == row_cnt) begin
            overlay[c] = 1'b1;
          end
        end
      end
    end
  end
`else
  logic unused_piece;
  assign unused_piece = ^{piece_x, piece_y, piece_valid};
  assign overlay      = '0;
`endif

  // ---------------------------------------------------------------- datapath
  always_comb begin
    row_cnt_nxt = row_cnt;
    bit_nxt     = bit_cnt;
    div_nxt     = div_cnt;
    gap_nxt     = gap_cnt;
    row_nxt     = row_q;
    if (frame_start) begin
      row_cnt_nxt = ROW_TOP;
    end
    case (state)
      CAPTURE: begin
        row_nxt = bus.rd_data | overlay;
        bit_nxt = BIT_TOP;
        div_nxt = '0;
      end
      SHIFT: begin
        if (div_cnt == DIV_LAST) begin
          div_nxt = '0;
          if (bit_cnt != '0) bit_nxt = bit_cnt - BIT_W'(1);
        end else begin
          div_nxt = div_cnt + DIV_W'(1);
        end
      end
      LATCH: begin
        if (row_cnt != '0) row_cnt_nxt = row_cnt - 5'd1;
        else               gap_nxt     = '0;
      end
      GAP: begin
        if (gap_cnt != GAP_LAST) gap_nxt = gap_cnt + GAP_W'(1);
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- outputs
  // Outputs are decoded from the next state/counters and registered so the
  // display lines come straight off flops and never glitch.
  always_comb begin
    rd_en_d      = (state_nxt == READ);
    latch_d      = (state_nxt == LATCH);
    busy_d       = (state_nxt != IDLE);
    sclk_d       = (state_nxt == SHIFT) && (div_nxt >= DIV_HALF);
    sdata_d      = (state_nxt == SHIFT) && row_nxt[bit_nxt];
    frame_done_d = (state == LATCH) && (state_nxt == GAP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_cnt      <= '0;
      bit_cnt      <= '0;
      div_cnt      <= '0;
      gap_cnt      <= '0;
      row_q        <= '0;
      rd_en_q      <= 1'b0;
      sdata_q      <= 1'b0;
      sclk_q       <= 1'b0;
      latch_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      row_sel_q    <= '0;
    end else begin
      row_cnt      <= row_cnt_nxt;
      bit_cnt      <= bit_nxt;
      div_cnt      <= div_nxt;
      gap_cnt      <= gap_nxt;
      row_q        <= row_nxt;
      rd_en_q      <= rd_en_d;
      sdata_q      <= sdata_d;
      sclk_q       <= sclk_d;
      latch_q      <= latch_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      if (latch_d) row_sel_q <= row_cnt;
    end
  end

  assign bus.rd_en   = rd_en_q;
  assign bus.rd_row  = row_cnt;
  assign bus.sdata   = sdata_q;
  assign bus.sclk    = sclk_q;
  assign bus.latch   = latch_q;
  assign bus.row_sel = row_sel_q;
  assign frame_done  = frame_done_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_board_scan.sv
// tb_board_scan: directed bench for board_scan with default parameters.
// A 1-cycle-latency board model feeds rd_data; a negedge monitor decodes the
// serial stream into per-row words and tracks latch order and timing.
module tb_board_scan;

  localparam int COLS      = 10;
  localparam int ROWS      = 20;
  localparam int ROW_CYC   = 83;
  localparam int FRAME_CYC = 1676;
`ifdef BOARD_SCAN_OVERLAY_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] piece_x = '0;
  logic [19:0] piece_y = '0;
  logic        piece_valid = 1'b0;
  logic        frame_done;
  logic        busy;

  board_scan_if #(.COLS(COLS)) bus ();

  board_scan #(
    .COLS(COLS),
    .ROWS(ROWS),
    .CLK_DIV(4),
    .FRAME_GAP(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .piece_x(piece_x),
    .piece_y(piece_y),
    .piece_valid(piece_valid),
    .frame_done(frame_done),
    .busy(busy),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Board read port model: registered, one cycle latency.
  logic [COLS-1:0] board [0:ROWS-1];
  initial bus.rd_data = '0;
  always @(posedge clk) if (bus.rd_en) bus.rd_data <= board[bus.rd_row];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  int              cyc = 0;
  int              lat_cnt = 0, seq_err = 0, ones = 0, stab_err = 0;
  int              hilen_err = 0, nbits_err = 0, gap_err = 0;
  int              nbits = 0, hi_len = 0, last_lat_cyc = 0, fd_cyc = 0;
  logic            sclk_prev = 1'b0, hi_bit = 1'b0;
  logic [COLS-1:0] bits = '0;
  logic [COLS-1:0] row_bits [0:31];

  always @(negedge clk) begin
    cyc++;
    if (bus.sdata) ones++;
    if (bus.sclk && !sclk_prev) begin
      bits   = {bits[COLS-2:0], bus.sdata};
      nbits++;
      hi_len = 1;
      hi_bit = bus.sdata;
    end else if (bus.sclk) begin
      hi_len++;
      if (bus.sdata !== hi_bit) stab_err++;
    end else if (sclk_prev) begin
      if (hi_len != 4) hilen_err++;
    end
    if (bus.latch) begin
      if (int'(bus.row_sel) != ROWS - 1 - lat_cnt) seq_err++;
      if (nbits != COLS) nbits_err++;
      if (lat_cnt > 0 && cyc - last_lat_cyc != ROW_CYC) gap_err++;
      row_bits[bus.row_sel] = bits;
      nbits        = 0;
      lat_cnt++;
      last_lat_cyc = cyc;
    end
    if (frame_done) fd_cyc = cyc;
    sclk_prev = bus.sclk;
  end

  task automatic clear_mon();
    lat_cnt = 0; seq_err = 0; ones = 0; stab_err = 0;
    hilen_err = 0; nbits_err = 0; gap_err = 0; nbits = 0;
    for (int i = 0; i < 32; i++) row_bits[i] = 'x;
  endtask

  task automatic wait_fd(input string tag, input int max_cyc);
    int n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!frame_done && n < max_cyc);
    check_eq(tag, {31'd0, frame_done}, 32'd1);
  endtask

  task automatic wait_lat(input string tag, input int cnt, input int max_cyc);
    int n = 0;
    while (lat_cnt < cnt && n < max_cyc) begin
      @(negedge clk); #1;
      n++;
    end
    check_eq(tag, {31'd0, lat_cnt >= cnt}, 32'd1);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int fd_a;
    int n;
    int rd_seen;
    logic [COLS-1:0] exp_sq;
    logic [COLS-1:0] exp_r17;
    exp_sq  = OVL ? 10'b00_0011_0000 : 10'b0;
    exp_r17 = OVL ? 10'b00_1000_0000 : 10'b0;
    for (int i = 0; i < ROWS; i++) board[i] = '0;
    clear_mon();

    // Reset values
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_rd_en",      {31'd0, bus.rd_en}, 32'd0);
    check_eq("rst_rd_row",     {27'd0, bus.rd_row}, 32'd0);
    check_eq("rst_sdata",      {31'd0, bus.sdata}, 32'd0);
    check_eq("rst_sclk",       {31'd0, bus.sclk}, 32'd0);
    check_eq("rst_latch",      {31'd0, bus.latch}, 32'd0);
    check_eq("rst_row_sel",    {27'd0, bus.row_sel}, 32'd0);
    check_eq("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check_eq("rst_busy",       {31'd0, busy}, 32'd0);

    // Release with enable: first read of the top row one edge later
    @(negedge clk);
    rst = 1'b1;
    enable = 1'b1;
    @(posedge clk); #1;
    check_eq("start_rd_en",  {31'd0, bus.rd_en}, 32'd1);
    check_eq("start_rd_row", {27'd0, bus.rd_row}, 32'd19);

    // Frame A: empty board, no piece
    wait_fd("frameA_done", 2000);
    check_eq("A_latches",   lat_cnt, 32'd20);
    check_eq("A_row_order", seq_err, 32'd0);
    check_eq("A_sdata_one", ones, 32'd0);
    check_eq("A_nbits",     nbits_err, 32'd0);
    check_eq("A_row_cyc",   gap_err, 32'd0);
    check_eq("A_sclk_high", hilen_err, 32'd0);
    fd_a = fd_cyc;

    // Frame B: two patterned rows plus a 2x2 piece at the top
    board[0] = 10'b10_0000_0001;
    board[5] = 10'b11_0000_0100;
    piece_x = {4'd5, 4'd4, 4'd5, 4'd4};
    piece_y = {5'd18, 5'd18, 5'd19, 5'd19};
    piece_valid = 1'b1;
    clear_mon();
    wait_lat("B_first_latch", 1, 300);
    // Moving the piece mid-frame must not affect this frame.
    piece_x = {4'd7, 4'd7, 4'd3, 4'd12};
    piece_y = {5'd17, 5'd17, 5'd21, 5'd18};
    wait_fd("frameB_done", 2000);
    check_eq("frame_period",   fd_cyc - fd_a, FRAME_CYC);
    check_eq("B_latches",      lat_cnt, 32'd20);
    check_eq("B_row0_bits",    {22'd0, row_bits[0]}, 32'b10_0000_0001);
    check_eq("B_row5_bits",    {22'd0, row_bits[5]}, 32'b11_0000_0100);
    check_eq("B_row19_piece",  {22'd0, row_bits[19]}, {22'd0, exp_sq});
    check_eq("B_row18_piece",  {22'd0, row_bits[18]}, {22'd0, exp_sq});
    check_eq("B_row17_nomove", {22'd0, row_bits[17]}, 32'd0);
    check_eq("B_sdata_stable", stab_err, 32'd0);
    check_eq("B_sclk_high",    hilen_err, 32'd0);
    check_eq("B_row_cyc",      gap_err, 32'd0);

    // Frame C: moved piece takes effect; enable drops during row 10
    clear_mon();
    wait_lat("C_nine_latches", 9, 1000);
    enable = 1'b0;
    check_eq("C_busy_midframe", {31'd0, busy}, 32'd1);
    wait_fd("frameC_done", 2000);
    check_eq("C_latches",      lat_cnt, 32'd20);
    check_eq("C_row_order",    seq_err, 32'd0);
    check_eq("C_row17_piece",  {22'd0, row_bits[17]}, {22'd0, exp_r17});
    check_eq("C_row18_x12",    {22'd0, row_bits[18]}, 32'd0);
    check_eq("C_row19_empty",  {22'd0, row_bits[19]}, 32'd0);
    check_eq("C_row0_bits",    {22'd0, row_bits[0]}, 32'b10_0000_0001);
    check_eq("C_busy_at_done", {31'd0, busy}, 32'd1);
    @(negedge clk); #1;
    check_eq("fd_one_cycle", {31'd0, frame_done}, 32'd0);
    repeat (14) @(negedge clk);
    #1;
    check_eq("gap_last_busy", {31'd0, busy}, 32'd1);
    @(negedge clk); #1;
    check_eq("idle_busy", {31'd0, busy}, 32'd0);
    rd_seen = 0;
    repeat (20) begin
      @(negedge clk); #1;
      if (bus.rd_en) rd_seen++;
    end
    check_eq("idle_no_read", rd_seen, 32'd0);

    // Frame D: reset asserted while shifting a '1' with sclk high
    board[19] = 10'h3FF;
    clear_mon();
    enable = 1'b1;
    n = 0;
    while (!(bus.sclk && bus.sdata) && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    check_eq("D_shift_seen", {31'd0, bus.sclk && bus.sdata}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check_eq("async_sclk",    {31'd0, bus.sclk}, 32'd0);
    check_eq("async_sdata",   {31'd0, bus.sdata}, 32'd0);
    check_eq("async_latch",   {31'd0, bus.latch}, 32'd0);
    check_eq("async_busy",    {31'd0, busy}, 32'd0);
    check_eq("async_rd_row",  {27'd0, bus.rd_row}, 32'd0);
    check_eq("no_part_latch", lat_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("restart_rd_en",  {31'd0, bus.rd_en}, 32'd1);
    check_eq("restart_rd_row", {27'd0, bus.rd_row}, 32'd19);
    clear_mon();
    wait_lat("D_first_latch", 1, 300);
    check_eq("D_row19_bits", {22'd0, row_bits[19]}, 32'h3FF);
    check_eq("D_row_order",  seq_err, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
